// File: rtl/fifo_param.sv
// ============================================================================
// Module   : fifo_param
// Brief    : Parametrised synchronous rts/rtr FIFO with watermarks, flush and
//            sticky error flags. Define FIFO_PARAM_FWFT_EN for first-word-
//            fall-through read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int AFULL_THR  = 6,
  parameter int AEMPTY_THR = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_flush,
  input  logic [DATA_W-1:0] fifo_inp_data,
  input  logic              fifo_inp_rts,
  output logic              fifo_inp_rtr,
  output logic [DATA_W-1:0] fifo_out_data,
  output logic              fifo_out_rts,
  input  logic              fifo_out_rtr,
  output logic [ADDR_W:0]   fifo_counter,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AFULL  = (ADDR_W+1)'(AFULL_THR);
  localparam logic [ADDR_W:0] C_AEMPTY = (ADDR_W+1)'(AEMPTY_THR);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              w_push;
  logic              w_pop;

  assign fifo_inp_rtr      = (count_q != C_DEPTH);
  assign fifo_out_rts      = (count_q != '0);
  assign fifo_counter      = count_q;
  assign fifo_almost_full  = (count_q >= C_AFULL);
  assign fifo_almost_empty = (count_q <= C_AEMPTY);
  assign fifo_overflow     = overflow_q;
  assign fifo_underflow    = underflow_q;

  // Flush discards any handshake in the same cycle, including the memory write.
  assign w_push = fifo_inp_rts & fifo_inp_rtr & ~fifo_flush;
  assign w_pop  = fifo_out_rts & fifo_out_rtr & ~fifo_flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (fifo_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (w_pop && !w_push) count_d = count_q - 1'b1;
      if (fifo_inp_rts && !fifo_inp_rtr) overflow_d  = 1'b1;
      if (fifo_out_rtr && !fifo_out_rts) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= fifo_inp_data;
  end

`ifdef FIFO_PARAM_FWFT_EN
  assign fifo_out_data = fifo_out_rts ? mem_q[rd_ptr_q] : '0;
`else
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_comb begin
    out_data_d = out_data_q;
    if (fifo_flush) out_data_d = '0;
    else if (w_pop) out_data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_data_q <= '0;
    else        out_data_q <= out_data_d;
  end

  assign fifo_out_data = out_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// ============================================================================
// Module   : tb_fifo_param
// Brief    : Directed vector bench for fifo_param (8-bit, 8-entry default).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_flush = 1'b0;
  logic [7:0] fifo_inp_data = '0;
  logic       fifo_inp_rts = 1'b0;
  logic       fifo_inp_rtr;
  logic [7:0] fifo_out_data;
  logic       fifo_out_rts;
  logic       fifo_out_rtr = 1'b0;
  logic [3:0] fifo_counter;
  logic       fifo_almost_full;
  logic       fifo_almost_empty;
  logic       fifo_overflow;
  logic       fifo_underflow;

  int n_vec = 0;
  int n_err = 0;

  fifo_param #(.DATA_W(8), .ADDR_W(3), .AFULL_THR(6), .AEMPTY_THR(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_flush       (fifo_flush),
    .fifo_inp_data    (fifo_inp_data),
    .fifo_inp_rts     (fifo_inp_rts),
    .fifo_inp_rtr     (fifo_inp_rtr),
    .fifo_out_data    (fifo_out_data),
    .fifo_out_rts     (fifo_out_rts),
    .fifo_out_rtr     (fifo_out_rtr),
    .fifo_counter     (fifo_counter),
    .fifo_almost_full (fifo_almost_full),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_overflow    (fifo_overflow),
    .fifo_underflow   (fifo_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic [3:0] cnt;
    logic       orts;
    logic       irtr;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
    logic [7:0] dat;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic fl, input logic wr, input logic [7:0] wd, input logic rd);
    @(negedge clk);
    fifo_flush    = fl;
    fifo_inp_rts  = wr;
    fifo_inp_data = wd;
    fifo_out_rtr  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fl, input logic wr, input logic [7:0] wd, input logic rd,
                     input logic [3:0] cnt, input logic orts, input logic irtr, input logic af,
                     input logic ae, input logic ov, input logic un, input logic [7:0] dat);
    vec_t v;
    v.fl = fl; v.wr = wr; v.wd = wd; v.rd = rd; v.cnt = cnt; v.orts = orts; v.irtr = irtr;
    v.af = af; v.ae = ae; v.ov = ov; v.un = un; v.dat = dat;
    tv.push_back(v);
  endtask

  initial begin
    // Fill 0x01..0x08 with the reader stalled.
    for (int k = 1; k <= 8; k++)
      add(0, 1, 8'(k), 0, 4'(k), 1, k != 8, k >= 6, k <= 2, 0, 0, 8'h00);
    // Write while full: overflow, nothing stored.
    add(0, 1, 8'hAA, 0, 8, 1, 0, 1, 0, 1, 0, 8'h00);
    // Drain in order.
    for (int k = 1; k <= 8; k++)
      add(0, 0, 8'h00, 1, 4'(8 - k), k != 8, 1, (8 - k) >= 6, (8 - k) <= 2, 1, 0, 8'(k));
    // Read while empty: underflow, data held.
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 1, 8'h08);
    // Flush with a concurrent write: everything cleared, write dropped.
    add(1, 1, 8'h77, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    // Simultaneous push/pop at count 3.
    add(0, 1, 8'h10, 0, 1, 1, 1, 0, 1, 0, 0, 8'h00);
    add(0, 1, 8'h11, 0, 2, 1, 1, 0, 1, 0, 0, 8'h00);
    add(0, 1, 8'h12, 0, 3, 1, 1, 0, 0, 0, 0, 8'h00);
    add(0, 1, 8'h55, 1, 3, 1, 1, 0, 0, 0, 0, 8'h10);
    add(0, 0, 8'h00, 1, 2, 1, 1, 0, 1, 0, 0, 8'h11);
    add(0, 0, 8'h00, 1, 1, 1, 1, 0, 1, 0, 0, 8'h12);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 0, 8'h55);

    // Async reset asserted mid-stream, checked before any clock edge.
    rst_n = 1'b1;
    step(0, 1, 8'hE1, 0);
    step(0, 1, 8'hE2, 0);
    chk("pre_reset_cnt", 32'(fifo_counter), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    fifo_inp_rts = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(fifo_counter), 32'd0);
    chk("async_rst_orts", 32'(fifo_out_rts), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_cnt", 32'(fifo_counter), 32'd0);
    chk("rst_orts", 32'(fifo_out_rts), 32'd0);
    chk("rst_irtr", 32'(fifo_inp_rtr), 32'd1);
    chk("rst_ae", 32'(fifo_almost_empty), 32'd1);
    chk("rst_af", 32'(fifo_almost_full), 32'd0);
    chk("rst_ov", 32'(fifo_overflow), 32'd0);
    chk("rst_un", 32'(fifo_underflow), 32'd0);
    chk("rst_data", 32'(fifo_out_data), 32'd0);

    foreach (tv[i]) begin
      step(tv[i].fl, tv[i].wr, tv[i].wd, tv[i].rd);
      chk($sformatf("v%0d_cnt", i), 32'(fifo_counter), 32'(tv[i].cnt));
      chk($sformatf("v%0d_orts", i), 32'(fifo_out_rts), 32'(tv[i].orts));
      chk($sformatf("v%0d_irtr", i), 32'(fifo_inp_rtr), 32'(tv[i].irtr));
      chk($sformatf("v%0d_af", i), 32'(fifo_almost_full), 32'(tv[i].af));
      chk($sformatf("v%0d_ae", i), 32'(fifo_almost_empty), 32'(tv[i].ae));
      chk($sformatf("v%0d_ov", i), 32'(fifo_overflow), 32'(tv[i].ov));
      chk($sformatf("v%0d_un", i), 32'(fifo_underflow), 32'(tv[i].un));
`ifndef FIFO_PARAM_FWFT_EN
      chk($sformatf("v%0d_data", i), 32'(fifo_out_data), 32'(tv[i].dat));
`endif
    end

    // Streaming push+pop across pointer wrap, one word resident.
    step(0, 1, 8'hA0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'(8'hA1 + i), 1);
      chk($sformatf("wrap%0d_cnt", i), 32'(fifo_counter), 32'd1);
`ifdef FIFO_PARAM_FWFT_EN
      chk($sformatf("wrap%0d_data", i), 32'(fifo_out_data), 32'(8'(8'hA1 + i)));
`else
      chk($sformatf("wrap%0d_data", i), 32'(fifo_out_data), 32'(8'(8'hA0 + i)));
`endif
    end
    step(0, 0, 8'h00, 1);
    chk("wrap_end_cnt", 32'(fifo_counter), 32'd0);

    // Full plus pop: write is refused (and flagged), pop still happens.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h20 + i), 0);
    step(0, 1, 8'h99, 1);
    chk("fullpop_cnt", 32'(fifo_counter), 32'd7);
    chk("fullpop_ov", 32'(fifo_overflow), 32'd1);
    for (int j = 1; j <= 7; j++) begin
      step(0, 0, 8'h00, 1);
      chk($sformatf("fullpop_drain%0d_cnt", j), 32'(fifo_counter), 32'(7 - j));
`ifdef FIFO_PARAM_FWFT_EN
      chk($sformatf("fullpop_drain%0d_data", j), 32'(fifo_out_data),
          (j < 7) ? 32'(8'h21 + j) : 32'd0);
`else
      chk($sformatf("fullpop_drain%0d_data", j), 32'(fifo_out_data), 32'(8'h20 + j));
`endif
    end

`ifdef FIFO_PARAM_FWFT_EN
    // Head word visible one cycle after the push, before any pop.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h3C, 0);
    chk("fwft_orts", 32'(fifo_out_rts), 32'd1);
    chk("fwft_data", 32'(fifo_out_data), 32'h3C);
    step(0, 0, 8'h00, 1);
    chk("fwft_empty_data", 32'(fifo_out_data), 32'd0);
`endif

    step(0, 0, 8'h00, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; successor to the fixed 8-bit, 8-entry rts/rtr FIFO.
- Generalises data width and depth.
- Adds:
  - almost-full and almost-empty watermarks
  - synchronous flush
  - sticky overflow and underflow error flags
  - optional first-word-fall-through read mode
- Sits between the i2si serialiser/deserialiser and its producer/consumer clients in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries.
- AFULL_THR, 6, fifo_almost_full asserts when count >= AFULL_THR (legal range 1..DEPTH).
- AEMPTY_THR, 2, fifo_almost_empty asserts when count <= AEMPTY_THR (legal range 0..DEPTH-1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_flush  in  1  synchronous clear of contents and error flags.
- fifo_inp_data  in  DATA_W  write data.
- fifo_inp_rts  in  1  writer has data (ready to send).
- fifo_inp_rtr  out  1  FIFO can accept (ready to receive).
- fifo_out_data  out  DATA_W  read data.
- fifo_out_rts  out  1  FIFO has data (ready to send).
- fifo_out_rtr  in  1  reader accepts (ready to receive).
- fifo_counter  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- fifo_almost_full  out  1  count >= AFULL_THR.
- fifo_almost_empty  out  1  count <= AEMPTY_THR.
- fifo_overflow  out  1  sticky: a write was attempted while full.
- fifo_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset, asynchronous on rst_n low:
  - wr_ptr = 0, rd_ptr = 0, fifo_counter = 0.
  - fifo_out_data = 0, fifo_overflow = 0, fifo_underflow = 0.
  - Memory contents are not reset.
  - Outputs derived after reset: fifo_inp_rtr = 1, fifo_out_rts = 0, fifo_almost_empty = 1, fifo_almost_full = 0.
- Derived outputs are combinational from the registered count:
  - fifo_inp_rtr = (count != DEPTH)
  - fifo_out_rts = (count != 0)
  - watermarks per the parameter rules above.
- Handshakes:
  - push = fifo_inp_rts & fifo_inp_rtr
  - pop = fifo_out_rts & fifo_out_rtr
- Push: mem[wr_ptr] <= fifo_inp_data; wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- Pop: rd_ptr increments modulo DEPTH.
- Count:
  - push only: +1.
  - pop only: -1.
  - both in the same cycle: unchanged, and both pointers advance.
- Full: fifo_inp_rtr = 0, so no push occurs even if a pop happens in the same cycle. There is no write-through-when-full.
- Empty: fifo_out_rts = 0, so no pop occurs. A push into an empty FIFO is poppable from the next cycle.
- Errors:
  - fifo_overflow sets on the edge where fifo_inp_rts=1 and fifo_inp_rtr=0.
  - fifo_underflow sets on the edge where fifo_out_rtr=1 and fifo_out_rts=0.
  - Both hold until flush or reset. Neither condition alters data, pointers or count.
- Flush, highest synchronous priority:
  - pointers = 0, count = 0, fifo_out_data = 0, both error flags = 0.
  - A push or pop in the same cycle is discarded.
- Reset mid-operation: all state returns to reset values immediately. Writes in flight are lost.

Optional Feature:
- Macro: FIFO_PARAM_FWFT_EN.
- Undefined (standard mode):
  - On a pop, fifo_out_data <= mem[rd_ptr] at that edge, so data is valid the cycle after the pop.
  - fifo_out_data holds its value otherwise.
- Defined (first-word-fall-through mode):
  - fifo_out_data = mem[rd_ptr] combinationally whenever fifo_out_rts = 1, so the head word is visible before the pop.
  - fifo_out_data = 0 when empty.
  - Pop consumes the displayed word.
  - Latency from push to fifo_out_rts and to data visible is 1 cycle.
- Flags, count and error behaviour are identical in both modes.

Test Plan:
- Reset: hold rst_n=0 mid-stream, then release -> counter=0, out_rts=0, inp_rtr=1, almost_empty=1, overflow=0, underflow=0, out_data=0.
- Fill and drain: push 0x01..0x08 with out_rtr=0 -> counter=8, inp_rtr=0, almost_full=1 from count 6. Then pop 8 times -> data returned in order 0x01..0x08, counter=0.
- Overflow: when full, assert inp_rts with 0xAA -> overflow=1, counter stays 8, 0xAA is never read out. Flush -> overflow=0, counter=0.
- Simultaneous push/pop: at count 3, push 0x55 and pop in the same cycle -> counter=3, oldest word popped. Push 20 words while popping to exercise pointer wrap -> no data loss.
- Underflow: when empty, assert out_rtr -> underflow=1, counter=0, out_data unchanged (standard) or 0 (FWFT).
- FWFT (macro defined): push 0x3C into an empty FIFO -> next cycle out_rts=1 and out_data=0x3C before any pop.
